decoder_struct: RTL and testbench
=================================

DECODER_STRUCT -- requirements
Module: decoder_struct

Interface
REQ-001 Parameter: OUT_ACTIVE_LOW, default 0, 1 inverts every bit of out (and only out) at the output port.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: en  input  1  decode enable; sampled on rising clk.
REQ-005 Port: in  input  2  binary select code; in[1] is MSB.
REQ-006 Port: out  output  4  registered one-hot decode of in.
REQ-007 Port: out_valid  output  1  high when out holds a decode of an enabled sample.
REQ-008 Port: dec_cnt  output  8  count of enabled decodes; present only when DECODER_STRUCT_CNT_EN is defined.

Function
REQ-009 Decode logic: built structurally from gate primitives (NOT/AND); one-hot term out_n[k] = 1 iff in == k, k = 0..3.
REQ-010 Mapping: in=00 -> out=0001; 01 -> 0010; 10 -> 0100; 11 -> 1000 (OUT_ACTIVE_LOW=0).
REQ-011 With OUT_ACTIVE_LOW=1: out is the bitwise inverse of REQ-010 (00 -> 1110, etc.); out_valid and dec_cnt are unaffected.
REQ-012 Latency: out and out_valid reflect the in/en sampled at a rising edge, visible after that edge; exactly 1 cycle.
REQ-013 en=1 at edge: out register loads decoded value; out_valid <= 1.
REQ-014 en=0 at edge: out register loads 0000 (all inactive; 1111 if OUT_ACTIVE_LOW=1); out_valid <= 0.
REQ-015 Exactly one bit of out is active whenever out_valid=1; no bit is active whenever out_valid=0.
REQ-016 Back-to-back: a new in value every cycle with en=1 produces a new one-hot every cycle, no bubbles.
REQ-017 in unchanged across cycles with en=1: out stays constant, out_valid stays 1.
REQ-018 No X propagation requirement on in when en=0; in is a don't-care then.

Reset
REQ-019 rst_n low: out = all inactive (0000, or 1111 with OUT_ACTIVE_LOW=1), out_valid = 0, dec_cnt = 0, immediately and without clk.
REQ-020 Reset asserted mid-operation: overrides any pending decode; outputs take reset values within the same cycle.
REQ-021 Reset release: first decode captured at the first rising edge with rst_n high and en=1.

Configuration
REQ-022 Macro DECODER_STRUCT_CNT_EN defined: dec_cnt port exists; increments by 1 on every rising edge with en=1; wraps 255 -> 0; holds when en=0.
REQ-023 Macro DECODER_STRUCT_CNT_EN undefined: no dec_cnt port, no counter logic; all other behaviour identical.

Verification
REQ-024 Reset: rst_n=0 with in=11, en=1, clk toggling -> out=0000, out_valid=0, dec_cnt=0.
REQ-025 Sweep: en=1, in=00,01,10,11 on successive edges -> out=0001,0010,0100,1000 each one edge later, out_valid=1.
REQ-026 Enable gating: en=0, in=10 -> out=0000, out_valid=0 after the edge; en=1 next edge -> out=0100.
REQ-027 Async reset mid-run: out=1000, pull rst_n low between edges -> out=0000 before next clk edge.
REQ-028 Counter (macro defined): 256 enabled edges from reset -> dec_cnt=0 (wrap); 3 more enabled, 2 disabled -> dec_cnt=3.
REQ-029 Polarity: OUT_ACTIVE_LOW=1, en=1, in=01 -> out=1101; en=0 -> out=1111.

Source files
------------

// File: rtl/decoder_struct.sv
`default_nettype none
// ============================================================================
// Module      : decoder_struct
// Description : Registered 2-to-4 one-hot decoder. The decode terms are built
//               from NOT/AND gate primitives and captured on the rising clock
//               edge when enabled. An optional output polarity inversion is
//               applied after the register.
//               Optional feature macro: DECODER_STRUCT_CNT_EN adds an 8-bit
//               wrapping count of enabled decodes on port dec_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
module decoder_struct #(
    parameter int unsigned OUT_ACTIVE_LOW = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] in,
    output logic [3:0] out,
    output logic       out_valid
`ifdef DECODER_STRUCT_CNT_EN
    ,
    output logic [7:0] dec_cnt
`endif
);

    // Inversion mask applied only at the out port; internal state stays
    // active-high so that reset and disable both map to "no bit active".
    localparam logic [3:0] c_pol_mask = (OUT_ACTIVE_LOW != 0) ? 4'hF : 4'h0;

    wire  [1:0] w_in_n;
    wire  [3:0] w_term;
    logic [3:0] r_onehot;
    logic       r_valid;

    // Structural decode: complement each select bit, then AND the matching
    // true/complement pair for each of the four minterms.
    not u_not0 (w_in_n[0], in[0]);
    not u_not1 (w_in_n[1], in[1]);

    and u_and0 (w_term[0], w_in_n[1], w_in_n[0]);
    and u_and1 (w_term[1], w_in_n[1], in[0]);
    and u_and2 (w_term[2], in[1],     w_in_n[0]);
    and u_and3 (w_term[3], in[1],     in[0]);

    // Capture the decoded term when enabled; a disabled edge clears to idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_onehot <= 4'b0000;
            r_valid  <= 1'b0;
        end else begin
            r_onehot <= en ? w_term : 4'b0000;
            r_valid  <= en;
        end
    end

    assign out       = r_onehot ^ c_pol_mask;
    assign out_valid = r_valid;

`ifdef DECODER_STRUCT_CNT_EN
    logic [7:0] r_dec_cnt;

    // Count enabled edges; natural 8-bit wrap from 255 back to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dec_cnt <= 8'd0;
        end else if (en) begin
            r_dec_cnt <= r_dec_cnt + 8'd1;
        end
    end

    assign dec_cnt = r_dec_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_decoder_struct.sv
`default_nettype none
// ============================================================================
// Module      : tb_decoder_struct
// Description : Self-checking bench for decoder_struct. Two instances share
//               the stimulus: one active-high, one with OUT_ACTIVE_LOW=1.
//               A behavioural model predicts the outputs from the select
//               code arithmetic; a compare process checks every cycle and
//               directed steps pin the model with literal expectations.
//               Honours DECODER_STRUCT_CNT_EN for the counter checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decoder_struct;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [1:0] in;
    logic [3:0] out_hi;
    logic [3:0] out_lo;
    logic       valid_hi;
    logic       valid_lo;
`ifdef DECODER_STRUCT_CNT_EN
    logic [7:0] cnt_hi;
    logic [7:0] cnt_lo;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    // Behavioural model state
    logic [3:0] exp_oh    = 4'b0000;
    logic       exp_valid = 1'b0;
    int         exp_cnt   = 0;

    decoder_struct #(.OUT_ACTIVE_LOW(0)) u_dut_hi (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in        (in),
        .out       (out_hi),
        .out_valid (valid_hi)
`ifdef DECODER_STRUCT_CNT_EN
        ,
        .dec_cnt   (cnt_hi)
`endif
    );

    decoder_struct #(.OUT_ACTIVE_LOW(1)) u_dut_lo (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in        (in),
        .out       (out_lo),
        .out_valid (valid_lo)
`ifdef DECODER_STRUCT_CNT_EN
        ,
        .dec_cnt   (cnt_lo)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a rising edge with en=1 selects bit number 'in'; reset clears.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_oh    <= 4'b0000;
            exp_valid <= 1'b0;
            exp_cnt   <= 0;
        end else begin
            exp_oh    <= en ? (4'b0001 << in) : 4'b0000;
            exp_valid <= en;
            if (en) exp_cnt <= (exp_cnt + 1) % 256;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("cyc_out_hi",   {4'b0, out_hi}, {4'b0, exp_oh});
        check("cyc_out_lo",   {4'b0, out_lo}, {4'b0, ~exp_oh});
        check("cyc_valid_hi", {7'b0, valid_hi}, {7'b0, exp_valid});
        check("cyc_valid_lo", {7'b0, valid_lo}, {7'b0, exp_valid});
`ifdef DECODER_STRUCT_CNT_EN
        check("cyc_cnt_hi", cnt_hi, exp_cnt[7:0]);
        check("cyc_cnt_lo", cnt_lo, exp_cnt[7:0]);
`endif
    end

    // Apply inputs just after an edge, then advance to 1ns past the next edge.
    task automatic tick(input logic e, input logic [1:0] i);
        en = e;
        in = i;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] sweep_exp [4];
        sweep_exp[0] = 4'b0001;
        sweep_exp[1] = 4'b0010;
        sweep_exp[2] = 4'b0100;
        sweep_exp[3] = 4'b1000;

        // Reset held with enabled, in=11 and clock running
        rst_n = 1'b0;
        en    = 1'b1;
        in    = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_hi",   {4'b0, out_hi}, 8'h00);
        check("rst_out_lo",   {4'b0, out_lo}, 8'h0F);
        check("rst_valid_hi", {7'b0, valid_hi}, 8'h00);
`ifdef DECODER_STRUCT_CNT_EN
        check("rst_cnt", cnt_hi, 8'h00);
`endif
        rst_n = 1'b1;

        // Sweep all codes back to back
        for (int k = 0; k < 4; k++) begin
            tick(1'b1, 2'(k));
            check("sweep_out_hi", {4'b0, out_hi}, {4'b0, sweep_exp[k]});
            check("sweep_valid",  {7'b0, valid_hi}, 8'h01);
        end

        // Held code keeps output constant
        tick(1'b1, 2'b11);
        check("hold_out_hi", {4'b0, out_hi}, 8'h08);

        // Enable gating
        tick(1'b0, 2'b10);
        check("gate_off_out",   {4'b0, out_hi}, 8'h00);
        check("gate_off_valid", {7'b0, valid_hi}, 8'h00);
        tick(1'b1, 2'b10);
        check("gate_on_out",    {4'b0, out_hi}, 8'h04);
        check("gate_on_out_lo", {4'b0, out_lo}, 8'h0B);

        // Polarity
        tick(1'b1, 2'b01);
        check("pol_en_out_lo",  {4'b0, out_lo}, 8'h0D);
        tick(1'b0, 2'b01);
        check("pol_dis_out_lo", {4'b0, out_lo}, 8'h0F);

        // Asynchronous reset between edges
        tick(1'b1, 2'b11);
        check("pre_arst_out", {4'b0, out_hi}, 8'h08);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_hi", {4'b0, out_hi}, 8'h00);
        check("arst_out_lo", {4'b0, out_lo}, 8'h0F);
        check("arst_valid",  {7'b0, valid_hi}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("release_first", {4'b0, out_hi}, 8'h08);

        // Randomized traffic with occasional async reset pulses
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 49) == 0) begin
                #2 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
            tick(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)));
        end

        // Counter wrap: 256 enabled edges from reset, then 3 on / 2 off
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        repeat (256) tick(1'b1, 2'($urandom_range(0, 3)));
`ifdef DECODER_STRUCT_CNT_EN
        check("cnt_wrap", cnt_hi, 8'h00);
`endif
        repeat (3) tick(1'b1, 2'b00);
        repeat (2) tick(1'b0, 2'b11);
`ifdef DECODER_STRUCT_CNT_EN
        check("cnt_after", cnt_hi, 8'h03);
`endif
        check("end_idle_out", {4'b0, out_hi}, 8'h00);

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
